sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//   Conditions raw active-low DIP-switch pins for the switch-display stage. Provides a
//   2-FF synchroniser, a shared-counter debouncer and polarity inversion.
//   Drives the display stage with a clean active-high value, the last stable value and a
//   one-cycle change strobe. Sits between board pins and the 7-seg/LED display logic.
// PARAMETERS
//   WIDTH      4        number of switch bits
//   DB_CYCLES  500000   clk cycles a new value must hold before acceptance (>=2; 5 ms @100 MHz)
// PORTS
//   clk        in   1      clock
//   resetn     in   1      reset: resetn, synchronous, active-low; clock clk
//   switch     in   WIDTH  raw pins, active-low (0 = switch on), asynchronous to clk
//   sw_data    out  WIDTH  debounced value, active-high (= ~accepted pins)
//   sw_prev    out  WIDTH  sw_data value before the most recent accepted change
//   sw_chg     out  1      1-cycle pulse on the cycle sw_data takes a new value
//   chg_cnt    out  8      accepted-change count (only with SW_DB_CHGCNT_EN)
// BEHAVIOUR
//   - Reset: sync1/sync2/cand/stable <= all-ones (switches off); sw_data=0, sw_prev=0,
//     sw_chg=0, cnt=0, chg_cnt=0. Reset mid-count discards the pending value.
//   - Synchroniser: sync1<=switch; sync2<=sync1. No logic reads sync1 except sync2.
//   - Debounce, evaluated each edge in priority order:
//     1. sync2!=cand: cand<=sync2, cnt<=0 (any glitch restarts the count).
//     2. cand!=stable, cnt==DB_CYCLES-1: stable<=cand, sw_prev<=sw_data, sw_chg<=1, cnt<=0.
//     3. cand!=stable: cnt<=cnt+1.
//     4. else cnt<=0.
//   - sw_data = ~stable, registered; sw_chg is 0 on every cycle not covered by rule 2.
//   - Latency: pin change set up before edge k and held steady -> sw_data/sw_chg valid
//     after edge k+DB_CYCLES+2.
//   - Pulse shorter than DB_CYCLES+1 cycles at sync2 -> no change, no sw_chg.
//   - Value returns to stable before acceptance -> rule 4 clears cnt; no sw_chg.
//   - Multi-bit change: one shared counter; bits changing on different cycles restart the
//     count and are accepted together as one sw_chg.
//   - Counter width $clog2(DB_CYCLES); cnt never exceeds DB_CYCLES-1.
// CONFIGURATION
//   SW_DB_CHGCNT_EN defined: chg_cnt increments on each sw_chg and wraps 255->0.
//   SW_DB_CHGCNT_EN undefined: chg_cnt port and counter are absent; all else is identical.
// STRUCTURE
//   sw_pkg: SW_WIDTH=4, SW_DB_CYCLES_DEF=500000, SW_OFF=all-ones idle pin pattern; shared
//   with the display stage.
//   Sub-module sync_2ff (WIDTH, RST_VAL params) holds the synchroniser pair; it is reused
//   for other board inputs.
// TESTING (DB_CYCLES=4, WIDTH=4)
//   1. Reset, switch=4'b1111 -> sw_data=0, sw_prev=0, sw_chg=0, chg_cnt=0.
//   2. switch 1111->1010 held before edge k -> sw_data=4'b0101 and sw_chg=1 after edge k+6
//      only; sw_prev=0.
//   3. switch 1010->1111 for 3 cycles, then back to 1010 -> no sw_chg; sw_data stays 0101.
//   4. bit0 falls at k, bit3 falls at k+2 -> single sw_chg after edge k+8; sw_data=4'b1001.
//   5. Value pending with cnt=2, resetn=0 for 1 cycle -> sw_data=0 and cnt=0. The still-held
//      value is re-accepted 6 cycles after reset release.
//   6. SW_DB_CHGCNT_EN: 257 accepted changes -> chg_cnt=1. Macro undefined: bench builds
//      without the port and tests 1-5 still pass.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared switch-path constants and types for the debouncer and the display stage.
package sw_pkg;

    localparam int SW_WIDTH         = 4;
    localparam int SW_DB_CYCLES_DEF = 500000;

    typedef logic [SW_WIDTH-1:0] sw_word_t;

    // Idle pin pattern: active-low pins read all-ones when every switch is off.
    localparam sw_word_t SW_OFF = '1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a selectable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // sync1 may be metastable; only sync2 samples it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/sw_debounce.sv
// Synchronises, debounces and inverts active-low switch pins for the display stage.
// Optional accepted-change counter on chg_cnt is built when SW_DB_CHGCNT_EN is defined.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH     = SW_WIDTH,
    parameter int DB_CYCLES = SW_DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] sw_data,
    output logic [WIDTH-1:0] sw_prev,
`ifdef SW_DB_CHGCNT_EN
    output logic [7:0]       chg_cnt,
`endif
    output logic             sw_chg
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [WIDTH-1:0] PIN_OFF = {WIDTH{1'b1}};

    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    sync_2ff #(
        .WIDTH   (WIDTH),
        .RST_VAL (PIN_OFF)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (switch),
        .q      (sync2)
    );

    // A candidate is accepted only after it has matched sync2 for DB_CYCLES edges.
    assign accept = (sync2 == cand) && (cand != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cand    <= PIN_OFF;
            stable  <= PIN_OFF;
            cnt     <= '0;
            sw_data <= '0;
            sw_prev <= '0;
            sw_chg  <= 1'b0;
        end else begin
            sw_chg <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (accept) begin
                stable  <= cand;
                sw_data <= ~cand;
                sw_prev <= sw_data;
                sw_chg  <= 1'b1;
                cnt     <= '0;
            end else if (cand != stable) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef SW_DB_CHGCNT_EN
    // Counts on the same edge that raises sw_chg; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            chg_cnt <= 8'd0;
        end else if (accept) begin
            chg_cnt <= chg_cnt + 8'd1;
        end
    end
`endif

endmodule
